wb_out_packer: RTL and testbench

Writeback output streamer sitting directly downstream of the writeback controller. It paces the controller's buffer walk by generating its advance strobe under a credit limit. It captures the BS or BP output-buffer read data selected for each advance and streams the beats out on a valid/ready master port, with `tlast` on the final beat of each tile. A `tile_done` pulse is issued once the last beat has left.

---
 rtl/wb_out_packer_pkg.sv | 18 +
 rtl/wb_skid_fifo.sv | 51 +++++
 rtl/wb_out_packer.sv | 122 ++++++++++++
 tb/tb_wb_out_packer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_out_packer_pkg.sv
// Shared types for the writeback output streamer: FSM states and the read-tag
// carried alongside each advance strobe.
package wb_out_packer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } wb_state_e;

  typedef struct packed {
    logic valid;
    logic sel;
    logic last;
  } wb_tag_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Show-ahead skid FIFO with registered occupancy; push while full is accepted
// when a pop happens in the same cycle.
module wb_skid_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_out_packer.sv
// Writeback output streamer: paces the controller's buffer walk under a credit
// limit, tags each read, and streams captured beats out with tlast/tile_done.
module wb_out_packer
  import wb_out_packer_pkg::*;
#(
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_tile_start,
  input  logic [15:0]       bs_bw_out_times,
  input  logic [15:0]       bp_bw_out_times,
  output logic              wb_valid_out,
  input  logic              wb_bs_bp_sel,
  input  logic              wb_tile_end,
  input  logic [DATA_W-1:0] bs_rd_data,
  input  logic [DATA_W-1:0] bp_rd_data,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              tile_done,
  output logic              busy,
  output logic              err_proto
);
  localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  wb_state_e       state, state_nx;
  logic [16:0]     total;
  logic [16:0]     issued;
  logic [15:0]     bs_beats;
  wb_tag_t         pipe [RD_LAT];
  wb_tag_t         tap;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     outstanding;
  logic            fifo_full, fifo_empty;
  logic [DATA_W:0] fifo_din, fifo_dout;
  logic            accept, strobe, strobe_last, is_bs, pop;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++)
      inflight = inflight + CW'(pipe[i].valid);
  end

  assign outstanding  = {1'b0, fifo_count} + {1'b0, inflight};
  assign accept       = wb_tile_start && (state == IDLE);
  assign strobe       = (state == RUN) && (issued != total) && !fifo_full
                        && (outstanding < DEPTH_C);
  assign strobe_last  = (issued == total - 17'd1);
  assign is_bs        = (issued < {1'b0, bs_beats});
  assign pop          = m_tvalid && m_tready;
  assign tap          = pipe[RD_LAT-1];
  assign fifo_din     = {tap.last, tap.sel ? bs_rd_data : bp_rd_data};

  assign wb_valid_out = strobe;
  assign busy         = (state != IDLE);
  assign tile_done    = (state == DONE);
  assign m_tvalid     = !fifo_empty;
  assign m_tdata      = fifo_dout[DATA_W-1:0];
  assign m_tlast      = fifo_dout[DATA_W] && m_tvalid;

  // Zero-length tiles spend one RUN cycle (no strobe) so tile_done lands at start+2.
  // DRAIN exits on the cycle the final beat pops so tile_done follows it directly.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (total == '0) state_nx = DONE;
               else if (strobe && strobe_last) state_nx = DRAIN;
      DRAIN:   if (inflight == '0 &&
                   (fifo_empty || (fifo_count == CW'(1) && pop))) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      total     <= '0;
      issued    <= '0;
      bs_beats  <= '0;
      err_proto <= 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        total    <= {1'b0, bs_bw_out_times} + {1'b0, bp_bw_out_times};
        issued   <= '0;
        bs_beats <= bs_bw_out_times;
      end else if (strobe) begin
        issued <= issued + 17'd1;
      end
      pipe[0] <= '{valid: strobe, sel: wb_bs_bp_sel, last: strobe && strobe_last};
      for (int unsigned i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      if (wb_tile_start && state != IDLE) err_proto <= 1'b1;
      if (strobe && ((wb_tile_end != strobe_last) || (wb_bs_bp_sel != is_bs)))
        err_proto <= 1'b1;
    end
  end

  wb_skid_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tap.valid),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_wb_out_packer.sv
// Bench for wb_out_packer: two instances (RD_LAT=1/DEPTH=4 and RD_LAT=3/DEPTH=8)
// driven by a controller/buffer model and checked against a per-tile beat list.
module tb_wb_out_packer;
  localparam int unsigned DW = 256;
  typedef logic [DW:0] val_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    rst, start, vout, sel, tend, tvalid, tready, tlast, tdone, busy, err;
  logic [15:0]   bs_n [2];
  logic [15:0]   bp_n [2];
  logic [DW-1:0] bs_d [2];
  logic [DW-1:0] bp_d [2];
  logic [DW-1:0] tdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_out_packer #(
      .DATA_W    (DW),
      .RD_LAT    ((g == 0) ? 1 : 3),
      .FIFO_DEPTH((g == 0) ? 4 : 8)
    ) u_dut (
      .clk            (clk),
      .rst            (rst[g]),
      .wb_tile_start  (start[g]),
      .bs_bw_out_times(bs_n[g]),
      .bp_bw_out_times(bp_n[g]),
      .wb_valid_out   (vout[g]),
      .wb_bs_bp_sel   (sel[g]),
      .wb_tile_end    (tend[g]),
      .bs_rd_data     (bs_d[g]),
      .bp_rd_data     (bp_d[g]),
      .m_tdata        (tdata[g]),
      .m_tvalid       (tvalid[g]),
      .m_tready       (tready[g]),
      .m_tlast        (tlast[g]),
      .tile_done      (tdone[g]),
      .busy           (busy[g]),
      .err_proto      (err[g])
    );
  end

  int unsigned cyc = 0;
  int unsigned n_chk = 0, n_pass = 0;
  int unsigned ready_mode [2], ctl_bs [2], ctl_total [2], k [2], inject_at [2], tile_id [2];
  val_t        exp_mem [2][256];
  int unsigned exp_wr [2], exp_rd [2];
  int unsigned pend_due [2][16], pend_k [2][16], pend_wr [2], pend_rd [2];
  int unsigned t_str [2], first_str [2], last_str [2];
  int unsigned t_hs [2], first_hs [2], last_hs [2], tv_cnt [2], done_cnt [2], done_cyc [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input val_t got, input val_t want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  function automatic int unsigned lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [DW-1:0] mk(input int i, input int unsigned t,
                                       input int unsigned j, input logic s);
    logic [31:0] w;
    w = {s ? 8'hB5 : 8'h0A, 4'(i), 4'(t), 16'(j)};
    return {8{w}};
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  // Controller and output-buffer model plus output monitor, one cycle at a time.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      case (ready_mode[i])
        0:       tready[i] = 1'b0;
        1:       tready[i] = 1'b1;
        default: tready[i] = 1'($urandom_range(0, 1));
      endcase
      sel[i]  = (k[i] < ctl_bs[i]);
      tend[i] = ((k[i] + 1 == ctl_total[i]) != (k[i] == inject_at[i]));
      if (pend_rd[i] != pend_wr[i] && pend_due[i][pend_rd[i] % 16] == cyc) begin
        bs_d[i] = mk(i, tile_id[i], pend_k[i][pend_rd[i] % 16], 1'b1);
        bp_d[i] = mk(i, tile_id[i], pend_k[i][pend_rd[i] % 16], 1'b0);
        pend_rd[i]++;
      end else begin
        bs_d[i] = rnd();
        bp_d[i] = rnd();
      end
      if (vout[i]) begin
        if (t_str[i] == 0) first_str[i] = cyc;
        last_str[i] = cyc;
        t_str[i]++;
        pend_due[i][pend_wr[i] % 16] = cyc + lat(i);
        pend_k[i][pend_wr[i] % 16]   = k[i];
        pend_wr[i]++;
        k[i]++;
      end
      if (tvalid[i]) tv_cnt[i]++;
      if (tvalid[i] && tready[i]) begin
        chk("beat_expected", val_t'(exp_rd[i] != exp_wr[i]), val_t'(1));
        if (exp_rd[i] != exp_wr[i]) begin
          chk("beat", {tlast[i], tdata[i]}, exp_mem[i][exp_rd[i] % 256]);
          exp_rd[i]++;
        end
        if (t_hs[i] == 0) first_hs[i] = cyc;
        last_hs[i] = cyc;
        t_hs[i]++;
      end
      if (tdone[i]) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_tile(input int i, input int unsigned b, input int unsigned p,
                            output int unsigned t);
    step();
    tile_id[i]++;
    ctl_bs[i] = b;  ctl_total[i] = b + p;  k[i] = 0;
    t_str[i] = 0;  t_hs[i] = 0;  tv_cnt[i] = 0;
    for (int unsigned j = 0; j < b + p; j++) begin
      exp_mem[i][exp_wr[i] % 256] = {1'(j == b + p - 1), mk(i, tile_id[i], j, j < b)};
      exp_wr[i]++;
    end
    start[i] = 1'b1;  bs_n[i] = 16'(b);  bp_n[i] = 16'(p);
    t = cyc;
    step();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int unsigned budget, input string tag);
    int unsigned d0 = done_cnt[i];
    int unsigned n = 0;
    while (done_cnt[i] == d0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, val_t'(done_cnt[i] != d0), val_t'(1));
  endtask

  task automatic check_reset(input int i);
    chk("rst_valid_out", val_t'(vout[i]), val_t'(0));
    chk("rst_tvalid",    val_t'(tvalid[i]), val_t'(0));
    chk("rst_tlast",     val_t'(tlast[i]), val_t'(0));
    chk("rst_tile_done", val_t'(tdone[i]), val_t'(0));
    chk("rst_busy",      val_t'(busy[i]), val_t'(0));
    chk("rst_err",       val_t'(err[i]), val_t'(0));
    chk("rst_tdata",     val_t'(tdata[i]), val_t'(0));
  endtask

  task automatic clear_model(input int i);
    k[i] = 0;  ctl_total[i] = 0;  ctl_bs[i] = 0;
    pend_rd[i] = pend_wr[i];  exp_rd[i] = exp_wr[i];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    rst = 2'b11;  start = '0;  sel = '0;  tend = '0;  tready = '0;
    for (int i = 0; i < 2; i++) begin
      bs_n[i] = '0;  bp_n[i] = '0;  bs_d[i] = '0;  bp_d[i] = '0;
      ready_mode[i] = 1;  ctl_bs[i] = 0;  ctl_total[i] = 0;  k[i] = 0;
      inject_at[i] = 32'hFFFF_FFFF;  tile_id[i] = 0;
      exp_wr[i] = 0;  exp_rd[i] = 0;  pend_wr[i] = 0;  pend_rd[i] = 0;
      t_str[i] = 0;  first_str[i] = 0;  last_str[i] = 0;  t_hs[i] = 0;
      first_hs[i] = 0;  last_hs[i] = 0;  tv_cnt[i] = 0;  done_cnt[i] = 0;  done_cyc[i] = 0;
    end
    repeat (3) step();
    check_reset(0);
    check_reset(1);
    rst = 2'b00;
    step();

    // Streaming, RD_LAT=1
    start_tile(0, 3, 2, t);
    wait_done(0, 50, "t1_done");
    chk("t1_first_str", val_t'(first_str[0]), val_t'(t + 1));
    chk("t1_nstr",      val_t'(t_str[0]), val_t'(5));
    chk("t1_last_str",  val_t'(last_str[0]), val_t'(t + 5));
    chk("t1_beats",     val_t'(t_hs[0]), val_t'(5));
    chk("t1_done_lat",  val_t'(done_cyc[0]), val_t'(last_hs[0] + 1));
    chk("t1_err",       val_t'(err[0]), val_t'(0));

    // Backpressure: credit limit stalls at FIFO_DEPTH strobes
    ready_mode[0] = 0;
    start_tile(0, 8, 0, t);
    repeat (20) step();
    chk("t2_stall_str", val_t'(t_str[0]), val_t'(4));
    chk("t2_busy",      val_t'(busy[0]), val_t'(1));
    ready_mode[0] = 1;
    wait_done(0, 100, "t2_done");
    chk("t2_beats",   val_t'(t_hs[0]), val_t'(8));
    chk("t2_drained", val_t'(exp_wr[0] - exp_rd[0]), val_t'(0));
    chk("t2_err",     val_t'(err[0]), val_t'(0));

    // Zero-length tile
    start_tile(0, 0, 0, t);
    wait_done(0, 20, "t3_done");
    chk("t3_done_cyc", val_t'(done_cyc[0]), val_t'(t + 2));
    chk("t3_nstr",     val_t'(t_str[0]), val_t'(0));
    chk("t3_tvalid",   val_t'(tv_cnt[0]), val_t'(0));

    // tile_end on strobe 2 of 4
    inject_at[0] = 1;
    start_tile(0, 2, 2, t);
    wait_done(0, 50, "t4_done");
    chk("t4_err",   val_t'(err[0]), val_t'(1));
    chk("t4_beats", val_t'(t_hs[0]), val_t'(4));
    inject_at[0] = 32'hFFFF_FFFF;
    repeat (3) step();
    chk("t4_err_sticky", val_t'(err[0]), val_t'(1));

    // Reset mid-tile with beats parked in the FIFO
    ready_mode[0] = 0;
    start_tile(0, 8, 0, t);
    repeat (4) step();
    chk("t5_tvalid_before", val_t'(tvalid[0]), val_t'(1));
    rst[0] = 1'b1;
    step();
    check_reset(0);
    rst[0] = 1'b0;
    clear_model(0);
    ready_mode[0] = 1;
    start_tile(0, 1, 1, t);
    wait_done(0, 50, "t5_done");
    chk("t5_nstr",  val_t'(t_str[0]), val_t'(2));
    chk("t5_beats", val_t'(t_hs[0]), val_t'(2));
    chk("t5_err",   val_t'(err[0]), val_t'(0));

    // tile_end missing on the last strobe
    inject_at[0] = 2;
    start_tile(0, 1, 2, t);
    wait_done(0, 50, "t5b_done");
    chk("t5b_err",   val_t'(err[0]), val_t'(1));
    chk("t5b_beats", val_t'(t_hs[0]), val_t'(3));
    inject_at[0] = 32'hFFFF_FFFF;

    // RD_LAT=3, random ready
    ready_mode[1] = 2;
    start_tile(1, 10, 6, t);
    wait_done(1, 400, "t6_done");
    chk("t6_beats",   val_t'(t_hs[1]), val_t'(16));
    chk("t6_drained", val_t'(exp_wr[1] - exp_rd[1]), val_t'(0));
    chk("t6_err",     val_t'(err[1]), val_t'(0));

    // RD_LAT=3, ready held high: one beat per cycle
    ready_mode[1] = 1;
    start_tile(1, 5, 7, t);
    wait_done(1, 100, "t6b_done");
    chk("t6b_first_str", val_t'(first_str[1]), val_t'(t + 1));
    chk("t6b_last_str",  val_t'(last_str[1]), val_t'(t + 12));
    chk("t6b_first_hs",  val_t'(first_hs[1]), val_t'(t + 5));
    chk("t6b_last_hs",   val_t'(last_hs[1]), val_t'(t + 16));
    chk("t6b_done_lat",  val_t'(done_cyc[1]), val_t'(last_hs[1] + 1));

    // Start while busy is ignored and flagged
    start_tile(1, 3, 3, t);
    step();
    start[1] = 1'b1;  bs_n[1] = 16'd9;  bp_n[1] = 16'd9;
    step();
    start[1] = 1'b0;
    wait_done(1, 100, "t7_done");
    chk("t7_err",   val_t'(err[1]), val_t'(1));
    chk("t7_nstr",  val_t'(t_str[1]), val_t'(6));
    chk("t7_beats", val_t'(t_hs[1]), val_t'(6));
    repeat (4) step();
    chk("t7_idle",       val_t'(busy[1]), val_t'(0));
    chk("t7_nstr_after", val_t'(t_str[1]), val_t'(6));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
